tty_writer: RTL



---
 rtl/tty_pkg.sv | 40 ++++
 rtl/tty_clear_seq.sv | 32 +++
 rtl/tty_writer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/tty_pkg.sv
// Shared constants, state encoding and lane packing for the glass-TTY writer.
package tty_pkg;

  localparam int COLS = 128;
  localparam int ROWS = 32;
  localparam int TABW = 8;
  localparam logic [6:0] DEFAULT_ATTR = 7'h07;

  localparam logic [6:0] LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
  localparam logic [6:0] TAB_MASK  = 7'(TABW - 1);
  localparam logic [4:0] ROW_LAST_WORD    = 5'd31;
  localparam logic [9:0] SCREEN_LAST_WORD = 10'd1023;

  typedef logic [2:0] state_t;
  localparam state_t IDLE    = 3'd0;
  localparam state_t PUTC    = 3'd1;
  localparam state_t CLRROW  = 3'd2;
  localparam state_t CLRSCR  = 3'd3;
  localparam state_t WSCROLL = 3'd4;
  localparam state_t WCURX   = 3'd5;
  localparam state_t WCURY   = 3'd6;

  localparam logic [11:0] SCROLL_ADDR = 12'h800;
  localparam logic [11:0] XCUR_ADDR   = 12'h802;
  localparam logic [11:0] YCUR_ADDR   = 12'h803;

  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] BS       = 8'h08;
  localparam logic [7:0] TAB      = 8'h09;
  localparam logic [7:0] FF       = 8'h0C;
  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  function automatic logic [15:0] lane_pack(input logic [6:0] attr, input logic [7:0] ascii);
    return {1'b0, attr, ascii};
  endfunction

endpackage

// File: rtl/tty_clear_seq.sv
// Word sequencer for row and full-screen clears of the character RAM.
module tty_clear_seq
  import tty_pkg::*;
(
  input  logic        clk_data,
  input  logic        irst,
  input  logic        start,
  input  logic        full,
  input  logic [4:0]  row,
  output logic [11:0] addr,
  output logic        last,
  output logic        done
);

  logic [9:0] cnt_r;

  // Word counter: restarts on reset or a new clear request, otherwise advances every cycle.
  always_ff @(posedge clk_data) begin
    if (irst) begin
      cnt_r <= 10'd0;
    end else if (start) begin
      cnt_r <= 10'd0;
    end else begin
      cnt_r <= cnt_r + 10'd1;
    end
  end

  assign addr = full ? {2'b00, cnt_r} : {1'b0, row, cnt_r[4:0]};
  assign last = ~full & (cnt_r[4:0] == ROW_LAST_WORD);
  assign done = full & (cnt_r == SCREEN_LAST_WORD);

endmodule

// File: rtl/tty_writer.sv
// Character-stream front end: interprets bytes, tracks cursor/scroll and
// issues character RAM and control-register writes on display port b.
module tty_writer
  import tty_pkg::*;
(
  input  logic        clk_data,
  input  logic        irst,
  input  logic [7:0]  in_data,
  input  logic [6:0]  in_attr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] addrb,
  output logic [63:0] dinb,
  output logic [7:0]  web,
  output logic        enb,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y
);

  state_t      state_r, state_s;
  logic [6:0]  attr_r, attr_s, x_s;
  logic [7:0]  ch_r, ch_s, tab_s;
  logic [4:0]  top_r, top_s, y_s, prow_s;
  logic        rdy_s, en_s, nl_s, clr_start_s, clr_last_s, clr_done_s;
  logic [7:0]  we_s;
  logic [11:0] addr_s, clr_addr_s;
  logic [63:0] din_s;

  assign prow_s = top_r + cur_y;
  assign tab_s  = {1'b0, cur_x | TAB_MASK} + 8'd1;

  tty_clear_seq u_clear (
    .clk_data (clk_data),
    .irst     (irst),
    .start    (clr_start_s),
    .full     (state_r == CLRSCR),
    .row      (prow_s),
    .addr     (clr_addr_s),
    .last     (clr_last_s),
    .done     (clr_done_s)
  );

  // Next-state, cursor and port-b access decode.
  always_comb begin
    state_s     = state_r;
    x_s         = cur_x;
    y_s         = cur_y;
    top_s       = top_r;
    ch_s        = ch_r;
    attr_s      = attr_r;
    rdy_s       = 1'b0;
    en_s        = 1'b0;
    we_s        = 8'h00;
    addr_s      = 12'h000;
    din_s       = 64'd0;
    nl_s        = 1'b0;
    clr_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready) begin
          ch_s    = in_data;
          attr_s  = in_attr;
          state_s = WCURX;
          case (in_data)
            CR:  x_s = 7'd0;
            LF:  nl_s = 1'b1;
            BS:  x_s = (cur_x != 7'd0) ? cur_x - 7'd1 : cur_x;
            TAB: begin
              if (tab_s[7]) begin
                x_s  = 7'd0;
                nl_s = 1'b1;
              end else begin
                x_s = tab_s[6:0];
              end
            end
            FF: begin
              state_s     = CLRSCR;
              clr_start_s = 1'b1;
            end
            default: begin
              if (in_data >= SPACE && in_data <= PRINT_HI) begin
                state_s = PUTC;
              end else begin
                state_s = WCURX;
              end
            end
          endcase
        end else begin
          rdy_s = 1'b1;
        end
      end
      PUTC: begin
        en_s   = 1'b1;
        addr_s = {1'b0, prow_s, cur_x[6:2]};
        we_s   = 8'b0000_0011 << {cur_x[1:0], 1'b0};
        din_s  = {48'd0, lane_pack(attr_r, ch_r)} << {cur_x[1:0], 4'b0000};
        if (cur_x != LAST_COL) begin
          x_s     = cur_x + 7'd1;
          state_s = WCURX;
        end else begin
          x_s  = 7'd0;
          nl_s = 1'b1;
        end
      end
      CLRROW: begin
        en_s   = 1'b1;
        we_s   = 8'hFF;
        addr_s = clr_addr_s;
        din_s  = {4{lane_pack(attr_r, SPACE)}};
        state_s = clr_last_s ? WSCROLL : CLRROW;
      end
      CLRSCR: begin
        en_s   = 1'b1;
        we_s   = 8'hFF;
        addr_s = clr_addr_s;
        din_s  = {4{lane_pack(attr_r, SPACE)}};
        if (clr_done_s) begin
          state_s = WSCROLL;
          top_s   = 5'd0;
          x_s     = 7'd0;
          y_s     = 5'd0;
        end else begin
          state_s = CLRSCR;
        end
      end
      WSCROLL: begin
        en_s    = 1'b1;
        we_s    = 8'hFF;
        addr_s  = SCROLL_ADDR;
        din_s   = {57'd0, 2'b00, top_r};
        state_s = WCURX;
      end
      WCURX: begin
        en_s    = 1'b1;
        we_s    = 8'hFF;
        addr_s  = XCUR_ADDR;
        din_s   = {57'd0, cur_x};
        state_s = WCURY;
      end
      WCURY: begin
        en_s    = 1'b1;
        we_s    = 8'hFF;
        addr_s  = YCUR_ADDR;
        din_s   = {57'd0, 2'b00, prow_s};
        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
    // Newline: step down a row, or scroll and blank the physical row that just became the bottom line.
    if (nl_s) begin
      if (cur_y != LAST_ROW) begin
        y_s     = cur_y + 5'd1;
        state_s = WCURX;
      end else begin
        top_s       = top_r + 5'd1;
        state_s     = CLRROW;
        clr_start_s = 1'b1;
      end
    end else begin
      y_s = y_s;
    end
  end

  // State, cursor and registered port-b outputs.
  always_ff @(posedge clk_data) begin
    if (irst) begin
      state_r  <= CLRSCR;
      attr_r   <= DEFAULT_ATTR;
      ch_r     <= 8'h00;
      top_r    <= 5'd0;
      cur_x    <= 7'd0;
      cur_y    <= 5'd0;
      in_ready <= 1'b0;
      enb      <= 1'b0;
      web      <= 8'h00;
      addrb    <= 12'h000;
      dinb     <= 64'd0;
    end else begin
      state_r  <= state_s;
      attr_r   <= attr_s;
      ch_r     <= ch_s;
      top_r    <= top_s;
      cur_x    <= x_s;
      cur_y    <= y_s;
      in_ready <= rdy_s;
      enb      <= en_s;
      web      <= we_s;
      addrb    <= addr_s;
      dinb     <= din_s;
    end
  end

endmodule
